cam_axis_bridge: RTL

//  Downstream of the camera pixel interface: runs on the buffered pixel clock and converts
//  the raw line/frame-valid pixel bus into AXI4-Stream video.

---
 rtl/cam_axis_bridge_if.sv | 21 ++
 rtl/cam_axis_bridge.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cam_axis_bridge_if.sv
// cam_axis_bridge_if
//   AXI4-Stream video bundle carried out of the camera bridge.
//   tdata  : pixel data (C_PIXEL_WIDTH bits)
//   tvalid : beat valid
//   tready : sink ready
//   tuser  : start of frame, first pixel of a frame only
//   tlast  : end of line, last pixel of each line
//   master : bridge side (drives tdata/tvalid/tuser/tlast)
//   slave  : sink side (drives tready)
interface cam_axis_bridge_if #(
  parameter int C_PIXEL_WIDTH = 8
);
  logic [C_PIXEL_WIDTH-1:0] tdata;
  logic                     tvalid;
  logic                     tready;
  logic                     tuser;
  logic                     tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/cam_axis_bridge.sv
// cam_axis_bridge
//   Converts a line/frame-valid camera pixel bus (pixel clock domain) into
//   AXI4-Stream video. Marks start of frame on tuser and end of line on tlast,
//   absorbs sink backpressure in a small first-word-fall-through FIFO, drops
//   the remainder of a frame when the FIFO overflows, and reports the
//   geometry of the last complete frame.
// Ports
//   pclk           : pixel clock, the only clock
//   rst_n          : asynchronous active-low reset
//   pixel_in       : pixel data, valid when line_valid_in & frame_valid_in
//   line_valid_in  : camera line valid
//   frame_valid_in : camera frame valid
//   m_axis         : AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   overflow       : sticky, set when a word had to be dropped
//   frame_width    : pixels in the last line of the last complete frame
//   frame_height   : lines in the last complete frame
//   frame_done     : one-cycle pulse when frame_width/frame_height update
module cam_axis_bridge #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_FIFO_DEPTH  = 16,
  parameter int C_CNT_WIDTH   = 12
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic [C_PIXEL_WIDTH-1:0] pixel_in,
  input  logic                     line_valid_in,
  input  logic                     frame_valid_in,
  cam_axis_bridge_if.master        m_axis,
  output logic                     overflow,
  output logic [C_CNT_WIDTH-1:0]   frame_width,
  output logic [C_CNT_WIDTH-1:0]   frame_height,
  output logic                     frame_done
);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int WW = C_PIXEL_WIDTH + 2;
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SYNC, IDLE, ACTIVE, DROP} state_t;
  state_t state, state_next;

  logic [C_PIXEL_WIDTH-1:0] pix_d, hold_data;
  logic                     lv_d, fv_d, fv_d2;
  logic                     hold_valid, sof_pending;
  logic [C_CNT_WIDTH-1:0]   pix_cnt, line_cnt, width_tmp;
  logic [C_CNT_WIDTH-1:0]   pix_cnt_inc, line_cnt_inc;

  logic [WW-1:0] mem [C_FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [WW-1:0] rd_word, push_word;
  logic          fifo_empty, fifo_full;

  logic pix_valid, fv_rise, fv_fall;
  logic push_req, push_last, push_drop, push_en, pop, line_end, frame_end;

  // fv_d/fv_d2 reset high so that no frame edge can be seen until the
  // camera bus has really been sampled; this keeps SYNC from leaving on
  // reset values while a frame is already running.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_d <= '0;
      lv_d  <= 1'b0;
      fv_d  <= 1'b1;
      fv_d2 <= 1'b1;
    end else begin
      pix_d <= pixel_in;
      lv_d  <= line_valid_in;
      fv_d  <= frame_valid_in;
      fv_d2 <= fv_d;
    end
  end

  assign pix_valid = lv_d & fv_d;
  assign fv_rise   = fv_d & ~fv_d2;
  assign fv_fall   = ~fv_d & fv_d2;

  // A held pixel leaves when its successor arrives (not last) or when the
  // valid window closes (last); a frame ending mid-line closes the line too.
  assign push_req  = (state == ACTIVE) & hold_valid;
  assign push_last = ~pix_valid;
  assign line_end  = push_en & push_last;
  assign pop       = m_axis.tvalid & m_axis.tready;
  assign push_drop = push_req & fifo_full & ~pop;
  assign push_en   = push_req & ~push_drop;
  assign push_word = {sof_pending, push_last, hold_data};

  assign pix_cnt_inc  = (pix_cnt == CNT_MAX)  ? pix_cnt  : pix_cnt + 1'b1;
  assign line_cnt_inc = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + 1'b1;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    case (state)
      SYNC:   if (!fv_d) state_next = IDLE;
      IDLE:   if (fv_rise) state_next = ACTIVE;
      ACTIVE: begin
        if (push_drop) begin
          state_next = DROP;
        end else if (fv_fall) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end
      end
      DROP:   if (!fv_d) state_next = IDLE;
      default: state_next = SYNC;
    endcase
  end

  // A line or frame can close in the same cycle as the final push, so the
  // geometry latch uses the post-increment values in that case.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data    <= '0;
      hold_valid   <= 1'b0;
      sof_pending  <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      width_tmp    <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE && fv_rise) begin
        sof_pending <= 1'b1;
        line_cnt    <= '0;
        pix_cnt     <= {{(C_CNT_WIDTH-1){1'b0}}, pix_valid};
        hold_valid  <= pix_valid;
        hold_data   <= pix_d;
      end else if (state == ACTIVE) begin
        if (push_drop) begin
          overflow   <= 1'b1;
          hold_valid <= 1'b0;
        end else begin
          if (push_en) sof_pending <= 1'b0;
          hold_valid <= pix_valid;
          if (pix_valid) begin
            hold_data <= pix_d;
            pix_cnt   <= pix_cnt_inc;
          end
          if (line_end) begin
            line_cnt  <= line_cnt_inc;
            width_tmp <= pix_cnt;
            pix_cnt   <= '0;
          end
          if (frame_end) begin
            frame_width  <= line_end ? pix_cnt : width_tmp;
            frame_height <= line_end ? line_cnt_inc : line_cnt;
            frame_done   <= 1'b1;
          end
        end
      end
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_word    = mem[rd_ptr[AW-1:0]];

  // Payload is forced to zero while empty so the stream is quiet after reset.
  assign m_axis.tvalid = ~fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0   : rd_word[C_PIXEL_WIDTH-1:0];
  assign m_axis.tlast  = fifo_empty ? 1'b0 : rd_word[C_PIXEL_WIDTH];
  assign m_axis.tuser  = fifo_empty ? 1'b0 : rd_word[C_PIXEL_WIDTH+1];
endmodule
